// File: rtl/decrement_counter_pkg.sv
// Shared constants and state encoding for the decrement counter.
// The counter top and its testbench both import this package.
package decrement_counter_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Plain encodings for code that compares raw state bits.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : decrement_counter_pkg

// File: rtl/decrement_counter_half_subtractor.sv
// One-bit half subtractor: D = A - B, Bo is the borrow out.
// Chained bit by bit to build the counter's decrementer.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic D,
    output logic Bo
);

    assign D  = A ^ B;
    assign Bo = ~A & B;

endmodule : half_subtractor

// File: rtl/decrement_counter.sv
// Loadable countdown counter with IDLE/RUN/DONE control.
// Loads init on start, decrements on step, pulses done for one cycle at zero.
module decrement_counter
    import decrement_counter_pkg::*;
#(
    parameter int WIDTH = decrement_counter_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] init,
    input  logic             step,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    logic [WIDTH-1:0] dec_value;
    logic [WIDTH-1:0] borrow;

    // Ripple borrow chain subtracting one: the first borrow-in is tied high.
    // The top borrow-out would only fire on 0-1, which RUN never requests.
    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sub
            if (gi < WIDTH - 1) begin : g_mid
                half_subtractor u_hs (
                    .A  (count_reg[gi]),
                    .B  (borrow[gi]),
                    .D  (dec_value[gi]),
                    .Bo (borrow[gi+1])
                );
            end else begin : g_last
                half_subtractor u_hs (
                    .A  (count_reg[gi]),
                    .B  (borrow[gi]),
                    .D  (dec_value[gi]),
                    .Bo ()
                );
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                // abort outranks start, so a simultaneous pair loads nothing
                if (start && !abort) begin
                    count_next = init;
                    state_next = (init != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (step) begin
                    count_next = dec_value;
                    if (dec_value == '0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);

endmodule : decrement_counter
